// File: rtl/regfile_pkg.sv
// Shared defaults and packed-port helpers for the scoreboarded register file.
package regfile_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_DEPTH  = 32;
  localparam int DEFAULT_NUM_RD = 2;

  // LSB position of port i inside a packed bus of w-bit fields
  function automatic int port_lsb(input int i, input int w);
    return i * w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: issue reserves a destination, writeback releases it.
module regfile_scoreboard #(
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  output logic [DEPTH-1:0] busy_vec,
  output logic             err_dbl_rsv
);

  logic             wr_zero;
  logic             rsv_zero;
  logic [DEPTH-1:0] clr_vec;
  logic [DEPTH-1:0] set_vec;
  logic [DEPTH-1:0] busy_nxt;
  logic             dbl_rsv;

  // Decode one-hot set/clear masks; a reservation beats a same-address write
  always_comb begin
    wr_zero  = (ZERO_REG != 0) && (wr_addr == '0);
    rsv_zero = (ZERO_REG != 0) && (rsv_addr == '0);
    clr_vec  = (wr_en && !wr_zero) ? (DEPTH'(1) << wr_addr) : '0;
    set_vec  = (rsv_en && !rsv_zero) ? (DEPTH'(1) << rsv_addr) : '0;
    busy_nxt = (busy_vec & ~clr_vec) | set_vec;
    // a write landing on the same register this cycle retires the old producer
    dbl_rsv  = rsv_en && !rsv_zero && busy_vec[rsv_addr] && !clr_vec[rsv_addr];
  end

  // Busy bits and the sticky double-reservation flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_vec    <= '0;
      err_dbl_rsv <= 1'b0;
    end else begin
      busy_vec <= busy_nxt;
      if (dbl_rsv) err_dbl_rsv <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with zero register, write bypass and busy scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int  WIDTH    = DEFAULT_WIDTH,
  parameter int  DEPTH    = DEFAULT_DEPTH,
  parameter int  NUM_RD   = DEFAULT_NUM_RD,
  parameter int  ZERO_REG = 1,
  parameter int  BYPASS   = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]       rd_pending,
  input  logic                    rsv_en,
  input  logic [AW-1:0]           rsv_addr,
  output logic [DEPTH-1:0]        busy_vec,
  output logic                    err_dbl_rsv
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_zero;
  logic             wr_live;

  assign wr_zero = (ZERO_REG != 0) && (wr_addr == '0);
  // bypass is also held off during reset so reads stay at zero
  assign wr_live = rst_n && wr_en && !wr_zero;

  // Storage array; register 0 is never written when it is hardwired
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en && !wr_zero) begin
      mem[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .rsv_en      (rsv_en),
    .rsv_addr    (rsv_addr),
    .busy_vec    (busy_vec),
    .err_dbl_rsv (err_dbl_rsv)
  );

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [AW-1:0] addr;
    logic          is_zero;
    logic          hit;

    assign addr    = rd_addr[port_lsb(g, AW) +: AW];
    assign is_zero = (ZERO_REG != 0) && (addr == '0);
    assign hit     = (BYPASS != 0) && wr_live && (wr_addr == addr);

    // Read mux: zero register first, then forwarded write data, then storage
    always_comb begin
      rd_data[port_lsb(g, WIDTH) +: WIDTH] = mem[addr];
      rd_pending[g] = busy_vec[addr];
      if (is_zero) begin
        rd_data[port_lsb(g, WIDTH) +: WIDTH] = '0;
        rd_pending[g] = 1'b0;
      end else if (hit) begin
        rd_data[port_lsb(g, WIDTH) +: WIDTH] = wr_data;
        rd_pending[g] = 1'b0;
      end
    end
  end

endmodule
